// File: rtl/alu_pkg.sv
// Purpose: shared opcode, flag-index and writeback-entry definitions for the ALU writeback path.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package alu_pkg;

    // Opcodes produced by the add/sub ALU; anything above ALU_OP_DEC is illegal.
    localparam logic [3:0] ALU_OP_ADD = 4'b0000;
    localparam logic [3:0] ALU_OP_INC = 4'b0001;
    localparam logic [3:0] ALU_OP_SUB = 4'b0010;
    localparam logic [3:0] ALU_OP_DEC = 4'b0011;

    // Bit positions inside the NZCV status register.
    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    // Default destination tag width of the register file.
    localparam int ALU_TAG_W = 5;

    // Writeback entry layout at the default tag width: data in the upper bits, tag below.
    typedef struct packed {
        logic [31:0]          data;
        logic [ALU_TAG_W-1:0] rd;
    } alu_wb_entry_t;

endpackage

// File: rtl/alu_wb_fifo.sv
// Purpose: generic synchronous FIFO with first-word fall-through off registered storage.
// Latency: a word pushed at edge k is visible on pop_dat_o in cycle k+1.
// Backpressure: push ignored when full, pop ignored when empty; no same-cycle full bypass.
module alu_wb_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 37
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         push_dat_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         pop_dat_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [PTR_W:0]   count_q;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             push_ok;
    logic             pop_ok;

    assign full_o    = (count_q == (PTR_W+1)'(DEPTH));
    assign empty_o   = (count_q == '0);
    assign count_o   = count_q;
    assign push_ok   = push_i && !full_o;
    assign pop_ok    = pop_i && !empty_o;
    assign pop_dat_o = mem_q[rd_ptr_q];

    // Pointer and occupancy tracking; pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop_ok) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   count_q <= count_q + (PTR_W+1)'(1);
                2'b01:   count_q <= count_q - (PTR_W+1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage write; contents need no reset because readers qualify on occupancy.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= push_dat_i;
        end
    end

endmodule

// File: rtl/alu_wb_stage.sv
// Purpose: ALU writeback stage - NZCV flag register, illegal-op pulse, retire counter, result FIFO.
// Latency: result accepted at edge k appears on wb_* in cycle k+1; flags update the cycle after accept.
// Backpressure: alu_ready = FIFO not full (registered state only); wb side is valid/ready.
// Optional: define ALU_WB_STICKY_OV_EN to add ov_clr / ov_sticky sticky-overflow tracking.
module alu_wb_stage
    import alu_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int TAG_W = ALU_TAG_W,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             alu_valid,
    output logic             alu_ready,
    input  logic [3:0]       alu_op,
    input  logic [31:0]      alu_out,
    input  logic             alu_carryout,
    input  logic             alu_overflow,
    input  logic             alu_zero,
    input  logic             alu_n,
    input  logic [TAG_W-1:0] alu_rd,
    output logic             wb_valid,
    input  logic             wb_ready,
    output logic [31:0]      wb_data,
    output logic [TAG_W-1:0] wb_rd,
`ifdef ALU_WB_STICKY_OV_EN
    input  logic             ov_clr,
    output logic             ov_sticky,
`endif
    output logic [3:0]       flags,
    output logic             err_illegal,
    output logic [CNT_W-1:0] retire_cnt
);

    // Entry layout matches alu_wb_entry_t but follows this instance's tag width.
    typedef struct packed {
        logic [31:0]      data;
        logic [TAG_W-1:0] rd;
    } entry_t;

    localparam int ENTRY_W = $bits(entry_t);

    entry_t                 push_ent;
    entry_t                 head_ent;
    logic [ENTRY_W-1:0]     head_raw;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic [$clog2(DEPTH):0] fifo_count;

    logic                   accept;
    logic                   op_legal;
    logic                   push;
    logic                   pop;

    logic [3:0]             flags_d;
    logic [3:0]             flags_q;
    logic                   err_illegal_q;
    logic [CNT_W-1:0]       retire_cnt_q;

    assign accept   = alu_valid && alu_ready;
    assign op_legal = (alu_op <= ALU_OP_DEC);
    assign push     = accept && op_legal;
    assign pop      = wb_ready && !fifo_empty;

    assign push_ent.data = alu_out;
    assign push_ent.rd   = alu_rd;
    assign head_ent      = entry_t'(head_raw);

    alu_wb_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .push_i     (push),
        .push_dat_i (push_ent),
        .pop_i      (pop),
        .pop_dat_o  (head_raw),
        .full_o     (fifo_full),
        .empty_o    (fifo_empty),
        .count_o    (fifo_count)
    );

    assign alu_ready = !fifo_full;
    assign wb_valid  = (fifo_count != '0);
    // Head fields are masked so stale storage never leaks when nothing is pending.
    assign wb_data   = wb_valid ? head_ent.data : 32'h0;
    assign wb_rd     = wb_valid ? head_ent.rd   : '0;

    // Status bits are taken exactly as the ALU delivered them.
    always_comb begin
        flags_d         = '0;
        flags_d[FLAG_N] = alu_n;
        flags_d[FLAG_Z] = alu_zero;
        flags_d[FLAG_C] = alu_carryout;
        flags_d[FLAG_V] = alu_overflow;
    end

    // Flag register updates only on legal accepts; illegal ops leave it untouched.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            flags_q <= '0;
        end else if (push) begin
            flags_q <= flags_d;
        end
    end

    // One-cycle error pulse for each accepted illegal opcode.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err_illegal_q <= 1'b0;
        end else begin
            err_illegal_q <= accept && !op_legal;
        end
    end

    // Retire counter counts completed writeback handshakes and wraps at its width.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            retire_cnt_q <= '0;
        end else if (pop) begin
            retire_cnt_q <= retire_cnt_q + CNT_W'(1);
        end
    end

`ifdef ALU_WB_STICKY_OV_EN
    logic ov_sticky_q;

    // Sticky overflow: a new overflow in the same cycle as a clear keeps the bit set.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ov_sticky_q <= 1'b0;
        end else if (push && alu_overflow) begin
            ov_sticky_q <= 1'b1;
        end else if (ov_clr) begin
            ov_sticky_q <= 1'b0;
        end
    end

    assign ov_sticky = ov_sticky_q;
`endif

    assign flags       = flags_q;
    assign err_illegal = err_illegal_q;
    assign retire_cnt  = retire_cnt_q;

endmodule

// File: doc/alu_wb_stage.md
Name: alu_wb_stage

Overview:
- Writeback stage directly downstream of the 32-bit add/sub ALU.
- Registers each ALU result together with its destination register tag.
- Updates an architectural NZCV status register.
- Buffers results in a small synchronous FIFO toward the register-file write port, with a valid/ready handshake on both sides.
- Decouples ALU issue from register-file write stalls.

Parameters:
- DEPTH, 2, FIFO entries (power of two, >=2).
- TAG_W, 5, destination register tag width.
- CNT_W, 16, retire counter width.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst_n  in  1  synchronous active-low reset.
- alu_valid  in  1  ALU result present this cycle.
- alu_ready  out  1  stage can accept; equals !full.
- alu_op  in  4  opcode that produced the result (0000 add, 0001 inc, 0010 sub, 0011 dec).
- alu_out  in  32  ALU result.
- alu_carryout  in  1  ALU carry.
- alu_overflow  in  1  ALU overflow.
- alu_zero  in  1  ALU zero.
- alu_n  in  1  ALU negative.
- alu_rd  in  TAG_W  destination register tag.
- wb_valid  out  1  head entry valid.
- wb_ready  in  1  register file accepts.
- wb_data  out  32  head result.
- wb_rd  out  TAG_W  head tag.
- flags  out  4  NZCV status register: bit3 N, bit2 Z, bit1 C, bit0 V.
- err_illegal  out  1  one-cycle pulse on an illegal opcode.
- retire_cnt  out  CNT_W  count of completed writebacks.

Behaviour:
- Reset (rst_n low at a clock edge):
  - FIFO emptied; count = 0.
  - flags = 0000, err_illegal = 0, retire_cnt = 0.
  - wb_valid = 0; wb_data and wb_rd = 0.
  - Reset mid-operation discards all buffered entries; no writeback handshake completes on the reset edge.
- Accept: occurs when alu_valid && alu_ready. alu_ready = (count != DEPTH), a pure function of registered state.
- Legal opcode (alu_op <= 0011) on accept:
  - Push {alu_out, alu_rd}.
  - flags <= {alu_n, alu_zero, alu_carryout, alu_overflow}, visible the cycle after accept.
  - Inputs are passed through unmodified. The stage does not recompute flags; a sub result carries C=0 as delivered.
- Illegal opcode (alu_op >= 0100) on accept:
  - Handshake completes and the entry is dropped.
  - flags unchanged.
  - err_illegal = 1 for exactly the next cycle.
- Pop: occurs when wb_valid && wb_ready.
  - Advances the head.
  - retire_cnt increments by 1, wrapping at 2^CNT_W-1 -> 0.
- wb_valid = (count != 0).
- wb_data and wb_rd reflect the head entry when wb_valid = 1, and are forced to 0 when wb_valid = 0.
- Latency: an entry accepted at edge k appears at the wb outputs in cycle k+1 (first-word fall-through off registered storage).
- Simultaneous push and pop: count unchanged, pointers both advance. Legal at any 0 < count < DEPTH.
- Full: alu_ready = 0, so no push is possible. A pop in that cycle drops count to DEPTH-1, and alu_ready rises the following cycle (no same-cycle bypass).
- Empty: pop impossible. A push makes wb_valid = 1 next cycle.
- Pointers are log2(DEPTH) bits and wrap naturally; count is log2(DEPTH)+1 bits.
- alu_valid with alu_ready = 0: input is ignored. The upstream holds its data stable.

Optional Feature:
- ALU_WB_STICKY_OV_EN defined:
  - Adds input ov_clr (1 bit) and output ov_sticky (1 bit).
  - ov_sticky sets on any legal accept with alu_overflow = 1, and holds until ov_clr = 1 or reset.
  - If set and clear occur in the same cycle, set wins.
  - Reset value 0.
- Not defined: neither port exists; behaviour is otherwise identical.

Decomposition:
- Shared package alu_pkg:
  - Opcode constants ALU_OP_ADD = 4'b0000, ALU_OP_INC = 4'b0001, ALU_OP_SUB = 4'b0010, ALU_OP_DEC = 4'b0011.
  - Flag index constants FLAG_N = 3, FLAG_Z = 2, FLAG_C = 1, FLAG_V = 0.
  - Typedef for the FIFO entry {data[31:0], rd[TAG_W-1:0]}.
- One sub-module: alu_wb_fifo, a generic synchronous FIFO (DEPTH, width) with push/pop/full/empty/count.
- The top level holds the flag register, illegal-op detection, the retire counter, and output masking.

Test Plan:
1. Reset then idle -> flags = 0000, wb_valid = 0, wb_data = 0, alu_ready = 1, retire_cnt = 0.
2. Push add result alu_out = 32'h0000_0005, rd = 3, flags inputs N0 Z0 C0 V0, wb_ready = 1 -> next cycle wb_valid = 1, wb_data = 5, wb_rd = 3; after the pop retire_cnt = 1, flags = 0000.
3. wb_ready = 0; push op 0011 with results 32'hFFFF_FFFF (N=1) then 32'h0 (Z=1) -> alu_ready = 0 after the second accept; flags = 0100; release wb_ready -> data pops in order FFFF_FFFF then 0.
4. Simultaneous push and pop at count = 1 for 10 cycles with wb_ready = 1 -> count stays 1, every result retired in order, retire_cnt = 10.
5. alu_op = 4'b0110 with alu_valid = 1 -> accepted, no FIFO entry, flags unchanged, err_illegal high exactly one cycle.
6. rst_n low while count = 2 -> next cycle count = 0, wb_valid = 0, flags = 0000. With ALU_WB_STICKY_OV_EN: an overflow accept followed by ov_clr in the same cycle as a second overflow -> ov_sticky remains 1.
